// File: rtl/sensor_protocol_pkg.sv
// Command/response codes and FSM encoding shared by the sensor request router.
// Codes are byte-wide so they pass straight through the UART command path.
package sensor_protocol_pkg;

   localparam int SENSOR_DATA_W = 8;

   localparam logic [7:0] CMD_STATUS        = 8'h00;
   localparam logic [7:0] CMD_TEMP          = 8'h01;
   localparam logic [7:0] CMD_HUM           = 8'h02;
   localparam logic [7:0] CMD_CONT_TEMP_ON  = 8'h03;
   localparam logic [7:0] CMD_CONT_HUM_ON   = 8'h04;
   localparam logic [7:0] CMD_CONT_TEMP_OFF = 8'h05;
   localparam logic [7:0] CMD_CONT_HUM_OFF  = 8'h06;

   localparam logic [7:0] RSP_OK            = 8'h07;
   localparam logic [7:0] RSP_HUM           = 8'h08;
   localparam logic [7:0] RSP_TEMP          = 8'h09;
   localparam logic [7:0] RSP_TEMP_OFF      = 8'h0A;
   localparam logic [7:0] RSP_HUM_OFF       = 8'h0B;
   localparam logic [7:0] RSP_FAULT         = 8'h1F;
   localparam logic [7:0] RSP_BAD_ADDR      = 8'hFE;
   localparam logic [7:0] RSP_BAD_CMD       = 8'hFF;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_DECODE  = 3'd1;
   localparam logic [2:0] ST_ISSUE   = 3'd2;
   localparam logic [2:0] ST_WAIT    = 3'd3;
   localparam logic [2:0] ST_RESPOND = 3'd4;

endpackage

// File: rtl/sensor_cycle_counter.sv
// Saturating up-counter with clear and enable; at_max flags the terminal count.
// Clear wins over enable; count holds at MAX_COUNT until cleared.
module sensor_cycle_counter #(
   parameter int MAX_COUNT = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic at_max
);

   localparam int W = (MAX_COUNT > 1) ? $clog2(MAX_COUNT + 1) : 1;
   localparam logic [W-1:0] MAX_V = W'(MAX_COUNT);

   logic [W-1:0] count;

   always_ff @(posedge clock) begin
      if (!reset || clear) begin
         count <= '0;
      end else if (enable && (count != MAX_V)) begin
         count <= count + 1'b1;
      end
   end

   assign at_max = (count == MAX_V);

endmodule

// File: rtl/sensor_request_router.sv
// Routes one request at a time to NUM_SENSORS sensor controllers; request_ready only in IDLE.
// Response 2 cycles after accept (invalid) or 1 after done/error; SENSOR_TIMEOUT_EN adds a WAIT timeout.
module sensor_request_router
   import sensor_protocol_pkg::*;
#(
   parameter int NUM_SENSORS    = 8,
   parameter int DATA_W         = SENSOR_DATA_W,
   parameter int CONT_PERIOD    = 50_000_000,
   parameter int TIMEOUT_CYCLES = 100_000_000
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          request_valid,
   output logic                          request_ready,
   input  logic [7:0]                    request_command,
   input  logic [7:0]                    request_address,
   output logic [NUM_SENSORS-1:0]        sensor_start,
   input  logic [NUM_SENSORS-1:0]        sensor_done,
   input  logic [NUM_SENSORS-1:0]        sensor_error,
   input  logic [NUM_SENSORS*DATA_W-1:0] sensor_hum,
   input  logic [NUM_SENSORS*DATA_W-1:0] sensor_temp,
   output logic                          response_valid,
   output logic [7:0]                    response_command,
   output logic [DATA_W-1:0]             response_value,
   output logic                          cont_active
);

   localparam int AW = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;

   logic [2:0]        state;
   logic [7:0]        cmd_q;
   logic [7:0]        addr_q;
   logic [7:0]        sess_cmd;
   logic [7:0]        sess_addr;
   logic [7:0]        resp_cmd;
   logic [DATA_W-1:0] resp_val;
   logic [AW-1:0]     sel;
   logic              period_done;

   assign sel           = addr_q[AW-1:0];
   assign request_ready = (state == ST_IDLE);
   assign sensor_start  = (state == ST_ISSUE) ? (NUM_SENSORS'(1) << sel) : '0;

   sensor_cycle_counter #(.MAX_COUNT(CONT_PERIOD - 1)) u_period_cnt (
      .clock  (clock),
      .reset  (reset),
      .clear  ((state == ST_RESPOND) || !cont_active),
      .enable ((state == ST_IDLE) && cont_active),
      .at_max (period_done)
   );

`ifdef SENSOR_TIMEOUT_EN
   logic timeout_hit;

   // Held clear outside WAIT so every wait starts counting from zero.
   sensor_cycle_counter #(.MAX_COUNT(TIMEOUT_CYCLES - 1)) u_timeout_cnt (
      .clock  (clock),
      .reset  (reset),
      .clear  (state != ST_WAIT),
      .enable (state == ST_WAIT),
      .at_max (timeout_hit)
   );
`endif

   always_ff @(posedge clock) begin
      if (!reset) begin
         state            <= ST_IDLE;
         cmd_q            <= '0;
         addr_q           <= '0;
         sess_cmd         <= '0;
         sess_addr        <= '0;
         resp_cmd         <= '0;
         resp_val         <= '0;
         cont_active      <= 1'b0;
         response_valid   <= 1'b0;
         response_command <= '0;
         response_value   <= '0;
      end else begin
         response_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (request_valid) begin
                  cmd_q  <= request_command;
                  addr_q <= request_address;
                  state  <= ST_DECODE;
               end else if (cont_active && period_done) begin
                  cmd_q  <= sess_cmd;
                  addr_q <= sess_addr;
                  state  <= ST_ISSUE;
               end
            end
            ST_DECODE: begin
               resp_val <= '0;
               if (cmd_q > CMD_CONT_HUM_OFF) begin
                  resp_cmd <= RSP_BAD_CMD;
                  state    <= ST_RESPOND;
               end else if (int'(addr_q) >= NUM_SENSORS) begin
                  resp_cmd <= RSP_BAD_ADDR;
                  state    <= ST_RESPOND;
               end else begin
                  case (cmd_q)
                     CMD_CONT_TEMP_OFF: begin
                        if (sess_cmd == CMD_TEMP) cont_active <= 1'b0;
                        resp_cmd <= RSP_TEMP_OFF;
                        state    <= ST_RESPOND;
                     end
                     CMD_CONT_HUM_OFF: begin
                        if (sess_cmd == CMD_HUM) cont_active <= 1'b0;
                        resp_cmd <= RSP_HUM_OFF;
                        state    <= ST_RESPOND;
                     end
                     CMD_CONT_TEMP_ON, CMD_CONT_HUM_ON: begin
                        // Sessions are stored as the equivalent one-shot read command.
                        sess_cmd    <= (cmd_q == CMD_CONT_TEMP_ON) ? CMD_TEMP : CMD_HUM;
                        cmd_q       <= (cmd_q == CMD_CONT_TEMP_ON) ? CMD_TEMP : CMD_HUM;
                        sess_addr   <= addr_q;
                        cont_active <= 1'b1;
                        state       <= ST_ISSUE;
                     end
                     default: state <= ST_ISSUE;
                  endcase
               end
            end
            ST_ISSUE: state <= ST_WAIT;
            ST_WAIT: begin
               if (sensor_error[sel]) begin
                  resp_cmd    <= RSP_FAULT;
                  resp_val    <= '0;
                  cont_active <= 1'b0;
                  state       <= ST_RESPOND;
               end else if (sensor_done[sel]) begin
                  if (cmd_q == CMD_STATUS) begin
                     resp_cmd <= RSP_OK;
                     resp_val <= '0;
                  end else if (cmd_q == CMD_HUM) begin
                     resp_cmd <= RSP_HUM;
                     resp_val <= sensor_hum[sel*DATA_W +: DATA_W];
                  end else begin
                     resp_cmd <= RSP_TEMP;
                     resp_val <= sensor_temp[sel*DATA_W +: DATA_W];
                  end
                  state <= ST_RESPOND;
               end
`ifdef SENSOR_TIMEOUT_EN
               else if (timeout_hit) begin
                  resp_cmd    <= RSP_FAULT;
                  resp_val    <= '0;
                  cont_active <= 1'b0;
                  state       <= ST_RESPOND;
               end
`endif
            end
            ST_RESPOND: begin
               response_valid   <= 1'b1;
               response_command <= resp_cmd;
               response_value   <= resp_val;
               state            <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
